serial_tx8: RTL
===============

# serial_tx8

Parallel-to-serial transmitter that feeds the 8:1 bit-select stage. It accepts an 8-bit word over a valid/ready handshake and steps a 3-bit select counter through the word positions, driving one bit per accepted output transfer. A one-word pending buffer lets consecutive words stream with no idle cycle between them.

## Interface
- `MSB_FIRST`, default 0: 0 sends bit 0 first; 1 sends bit 7 first.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  producer offers `in_data`.
- `in_data`  in  8  word to serialize.
- `in_ready`  out  1  transmitter can accept a word.
- `out_valid`  out  1  `out_bit` holds a valid bit.
- `out_ready`  in  1  consumer takes `out_bit`.
- `out_bit`  out  1  current serial bit.
- `out_last`  out  1  `out_bit` is the final bit of the word.
- `s`  out  3  current select index (0..7). This is the transfer order, not the physical bit index.

## Operation
- Registers:
  - `active[7:0]`: word being sent.
  - `pend[7:0]` and `pend_full`: pending buffer.
  - `sel[2:0]`: position counter.
  - `state`: IDLE or SEND.
- Input handshake:
  - `in_ready = !pend_full`, combinational.
  - A word is accepted when `in_valid && in_ready` at a rising edge.
- Output handshake:
  - `out_valid = (state == SEND)`.
  - A bit transfers when `out_valid && out_ready` at a rising edge.
- Bit selection:
  - `out_bit = active[sel]` when `MSB_FIRST = 0`; `active[7 - sel]` when `MSB_FIRST = 1`.
  - `out_bit` is 0 when `out_valid` is 0.
- `out_last = out_valid && (sel == 7)`.
- `s = sel`.
- IDLE:
  - Accept loads the word into `active`, clears `sel` to 0, moves to SEND.
  - `pend_full` stays 0.
- SEND, transfer with `sel < 7`: `sel` increments by 1.
- SEND, transfer with `sel == 7` (last bit), in priority order:
  1. If `pend_full`: load `pend` into `active`, clear `pend_full`, set `sel` to 0, stay in SEND.
  2. Else, if an accept happens the same edge: load `in_data` directly into `active`, set `sel` to 0, stay in SEND (no bubble).
  3. Else: go to IDLE with `sel` at 0.
- SEND, accept that is not covered by rule 2 (pending is empty by definition): load `pend`, set `pend_full`.
- No transfer: `sel`, `active` and `out_bit` hold. This holds in any state.
- `sel` wraps from 7 to 0 only on a last-bit transfer. It never wraps on its own.

## Timing
- Reset values, applied immediately on `rst_n` falling, independent of `clk`:
  - `state` = IDLE, `sel` = 0, `pend_full` = 0, `active` = 0, `pend` = 0.
  - Outputs: `in_ready` = 1, `out_valid` = 0, `out_bit` = 0, `out_last` = 0, `s` = 0.
- Reset release:
  - Takes effect asynchronously.
  - First accept is possible at the first rising edge with `rst_n` high.
- Latency: a word accepted at edge N while IDLE gives `out_valid` = 1 with its first bit in the cycle after edge N.
- Throughput:
  - 1 bit per cycle with `out_ready` held at 1.
  - 8 cycles per word.
  - Back-to-back words show no `out_valid` gap.
- Back-pressure: `out_ready` low holds `out_bit`, `out_last` and `s` stable for any duration.
- Producer stall: `in_ready` falls the cycle after `pend` fills. It rises the cycle after the last-bit transfer that moves `pend` into `active`.
- Reset mid-word:
  - Any in-flight bit and any pending word are discarded.
  - No partial word continues after release.

## Test plan
- Reset values: assert `rst_n` = 0 mid-cycle with no clock edge → all outputs at reset values immediately; `in_ready` = 1.
- Single word, LSB first: `MSB_FIRST` = 0, `in_data` = 8'hC9, `out_ready` = 1 → `out_bit` = 1,0,0,1,0,0,1,1 over 8 consecutive cycles, `s` = 0..7, `out_last` = 1 only on the 8th, then `out_valid` = 0.
- Back-pressure: toggle `out_ready` 1,0,0,1,... during 8'hC9 → the bit sequence is unchanged, and `out_bit` and `s` stay stable while `out_ready` = 0.
- Streaming: offer 8'hC9, 8'h0F and 8'hA5 continuously with `out_ready` = 1 → 24 consecutive valid bits, no gap; `in_ready` drops while `pend` is full; `out_last` at cycles 8, 16 and 24.
- Simultaneous accept and last transfer with `pend` empty: 8'h0F arrives on the edge of the last bit of 8'hC9 → the next cycle shows `s` = 0, `out_bit` = 1, with no IDLE cycle.
- Reset mid-word plus MSB-first:
  - `MSB_FIRST` = 1, send 8'hC9, assert `rst_n` low at `s` = 3 → immediate reset state.
  - After release, sending 8'hC9 yields 1,1,0,0,1,0,0,1.

Source files
------------

// File: rtl/serial_tx8_if.sv
// rtl/serial_tx8_if.sv - handshake bundle between word producer, serial_tx8 and bit consumer
//
// Signals:
//   in_valid  producer offers in_data
//   in_data   8-bit word to serialize
//   in_ready  transmitter can accept a word
//   out_valid out_bit holds a valid bit
//   out_ready consumer takes out_bit
//   out_bit   current serial bit
//   out_last  out_bit is the final bit of its word
//   s         current select index (transfer order, 0..7)
// Modports:
//   slave  - the transmitter side
//   master - the producer/consumer side driving the transmitter
interface serial_tx8_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready;
    logic       out_bit;
    logic       out_last;
    logic [2:0] s;

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_bit,
        output out_last,
        output s
    );

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_bit,
        input  out_last,
        input  s
    );
endinterface

// File: rtl/serial_tx8.sv
// rtl/serial_tx8.sv - parallel-to-serial transmitter with one-word pending buffer
//
// Parameters:
//   MSB_FIRST  0: bit 0 of the word goes out first; 1: bit 7 goes out first
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    serial_tx8_if.slave - word input handshake, serial bit output handshake, select index
module serial_tx8 #(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic           clk,
    input  logic           rst_n,
    serial_tx8_if.slave    bus
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t     r_state;
    logic [7:0] r_active;
    logic [7:0] r_pend;
    logic       r_pend_full;
    logic [2:0] r_sel;

    state_t     w_state_nxt;
    logic [7:0] w_active_nxt;
    logic [7:0] w_pend_nxt;
    logic       w_pend_full_nxt;
    logic [2:0] w_sel_nxt;

    logic       w_accept;
    logic       w_xfer;
    logic       w_last_xfer;
    logic [2:0] w_idx;

    assign bus.in_ready  = !r_pend_full;
    assign bus.out_valid = (r_state == ST_SEND);
    assign bus.out_last  = bus.out_valid && (r_sel == 3'd7);
    assign bus.s         = r_sel;

    assign w_accept    = bus.in_valid && !r_pend_full;
    assign w_xfer      = bus.out_valid && bus.out_ready;
    assign w_last_xfer = w_xfer && (r_sel == 3'd7);

    // sel is the transfer position; map it to the physical bit index
    assign w_idx       = MSB_FIRST ? (3'd7 - r_sel) : r_sel;
    assign bus.out_bit = bus.out_valid ? r_active[w_idx] : 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_active    <= 8'h00;
            r_pend      <= 8'h00;
            r_pend_full <= 1'b0;
            r_sel       <= 3'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_active    <= w_active_nxt;
            r_pend      <= w_pend_nxt;
            r_pend_full <= w_pend_full_nxt;
            r_sel       <= w_sel_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_active_nxt    = r_active;
        w_pend_nxt      = r_pend;
        w_pend_full_nxt = r_pend_full;
        w_sel_nxt       = r_sel;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_active_nxt = bus.in_data;
                    w_sel_nxt    = 3'd0;
                    w_state_nxt  = ST_SEND;
                end
            end
            ST_SEND: begin
                if (w_xfer) begin
                    if (!w_last_xfer) begin
                        w_sel_nxt = r_sel + 3'd1;
                    end else if (r_pend_full) begin
                        w_active_nxt    = r_pend;
                        w_pend_full_nxt = 1'b0;
                        w_sel_nxt       = 3'd0;
                    end else if (w_accept) begin
                        // word arriving on the last-bit edge bypasses pend: no bubble
                        w_active_nxt = bus.in_data;
                        w_sel_nxt    = 3'd0;
                    end else begin
                        w_sel_nxt   = 3'd0;
                        w_state_nxt = ST_IDLE;
                    end
                end
                // an accept can only coincide with pend empty; unless it went
                // straight into active above, it parks in pend
                if (w_accept && !(w_last_xfer && !r_pend_full)) begin
                    w_pend_nxt      = bus.in_data;
                    w_pend_full_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule
